// File: rtl/mem_datos_param.sv
// rtl/mem_datos_param.sv - word-addressed data memory with byte enables, registered read and range check
// Read-first on same-address read/write; out-of-range accesses raise a pulse and a sticky flag.
module mem_datos_param #(
  parameter int                 DATA_W      = 32,
  parameter int                 DEPTH       = 16,
  parameter logic [31:0]        BASE_ADDR   = 32'h10000000,
  parameter logic [DATA_W-1:0]  DEFAULT_VAL = 'h20,
  parameter bit                 RESET_INIT  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Mem_rd,
  input  logic                Mem_wr,
  input  logic [DATA_W/8-1:0] Byte_en,
  input  logic [31:0]         Dir_Mem,
  input  logic [DATA_W-1:0]   Dato_Mem_in,
  output logic [DATA_W-1:0]   Dato_Mem_out,
  output logic                Rd_valid,
  output logic                Addr_err,
  output logic                Err_sticky,
  input  logic                Err_clr
);

  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);

  function automatic logic [DATA_W-1:0] init_word(input int i);
    if (!RESET_INIT) return '0;
    case (i)
      0:       return DATA_W'(8'h10);
      1:       return DATA_W'(8'h08);
      2:       return DATA_W'(8'h0D);
      3:       return DATA_W'(8'h02);
      default: return '0;
    endcase
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic              rd_valid_q;
  logic              addr_err_q;
  logic              sticky_q;

  logic [32:0]       off_d;
  logic [AW-1:0]     idx_d;
  logic              in_range_d;
  logic              acc_rd_d;
  logic              acc_wr_d;
  logic              err_d;
  logic [DATA_W-1:0] wr_word_d;

  // 33-bit difference: bit 32 set means Dir_Mem < BASE_ADDR, so no wrap near 32'hFFFFFFFF.
  always_comb begin
    off_d      = {1'b0, Dir_Mem} - {1'b0, BASE_ADDR};
    in_range_d = (Dir_Mem >= BASE_ADDR) && (off_d < 33'(DEPTH));
    idx_d      = off_d[AW-1:0];
    acc_rd_d   = !Mem_rd;
    acc_wr_d   = !Mem_wr && (|Byte_en);
    err_d      = !in_range_d && (acc_rd_d || acc_wr_d);
    wr_word_d  = mem_q[idx_d];
    for (int b = 0; b < NB; b++) begin
      if (Byte_en[b]) wr_word_d[8*b +: 8] = Dato_Mem_in[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
      sticky_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= init_word(i);
    end else begin
      rd_valid_q <= acc_rd_d;
      addr_err_q <= err_d;
      if (acc_rd_d) dout_q <= in_range_d ? mem_q[idx_d] : DEFAULT_VAL;
      if (err_d)        sticky_q <= 1'b1;
      else if (Err_clr) sticky_q <= 1'b0;
      if (acc_wr_d && in_range_d) mem_q[idx_d] <= wr_word_d;
    end
  end

  assign Dato_Mem_out = dout_q;
  assign Rd_valid     = rd_valid_q;
  assign Addr_err     = addr_err_q;
  assign Err_sticky   = sticky_q;

endmodule

// File: tb/tb_mem_datos_param.sv
// tb/tb_mem_datos_param.sv - self-checking bench for mem_datos_param
// Reference model: plain word array with signed address offset arithmetic.
module tb_mem_datos_param;

  localparam logic [31:0] BASE = 32'h10000000;
  localparam int          DEP  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        Mem_rd, Mem_wr, Err_clr;
  logic [3:0]  Byte_en;
  logic [31:0] Dir_Mem, Dato_Mem_in, Dato_Mem_out;
  logic        Rd_valid, Addr_err, Err_sticky;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [DEP];
  logic [31:0] exp_out;
  logic        exp_valid, exp_err, exp_sticky;

  always #5 clk = ~clk;

  mem_datos_param #(
    .DATA_W(32), .DEPTH(DEP), .BASE_ADDR(BASE),
    .DEFAULT_VAL(32'h20), .RESET_INIT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .Mem_rd(Mem_rd), .Mem_wr(Mem_wr), .Byte_en(Byte_en),
    .Dir_Mem(Dir_Mem), .Dato_Mem_in(Dato_Mem_in), .Dato_Mem_out(Dato_Mem_out),
    .Rd_valid(Rd_valid), .Addr_err(Addr_err), .Err_sticky(Err_sticky), .Err_clr(Err_clr)
  );

  task automatic model_reset();
    for (int i = 0; i < DEP; i++) model[i] = 32'h0;
    model[0] = 32'h10; model[1] = 32'h08; model[2] = 32'h0D; model[3] = 32'h02;
    exp_out = 0; exp_valid = 0; exp_err = 0; exp_sticky = 0;
  endtask

  // Drives one cycle of stimulus, advances the model, returns 1 ns after the edge.
  task automatic access(input bit rd, input bit wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] data, input bit clr);
    longint off;
    bit     inr;
    Mem_rd = !rd; Mem_wr = !wr; Byte_en = be; Dir_Mem = addr;
    Dato_Mem_in = data; Err_clr = clr;
    off = longint'(addr) - longint'(BASE);
    inr = (off >= 0) && (off < DEP);
    exp_valid = rd;
    if (rd) exp_out = inr ? model[int'(off)] : 32'h20;
    exp_err = !inr && (rd || (wr && be != 4'b0));
    if (exp_err) exp_sticky = 1'b1;
    else if (clr) exp_sticky = 1'b0;
    if (wr && inr)
      for (int b = 0; b < 4; b++)
        if (be[b]) model[int'(off)][8*b +: 8] = data[8*b +: 8];
    @(posedge clk);
    #1;
    Mem_rd = 1'b1; Mem_wr = 1'b1; Byte_en = 4'h0; Err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; Mem_rd = 1'b1; Mem_wr = 1'b1; Byte_en = 0; Dir_Mem = 0;
    Dato_Mem_in = 0; Err_clr = 0;
    model_reset();
    #12;
    checks++;
    if ({Dato_Mem_out, Rd_valid, Addr_err, Err_sticky} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%h v=%b e=%b s=%b want all 0",
               Dato_Mem_out, Rd_valid, Addr_err, Err_sticky);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_init_reads();
    logic [31:0] want [4];
    want[0] = 32'h10; want[1] = 32'h08; want[2] = 32'h0D; want[3] = 32'h02;
    for (int i = 0; i < 4; i++) begin
      access(1, 0, 4'h0, BASE + i, 32'h0, 0);
      checks++;
      if (Dato_Mem_out !== want[i] || Rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL init_read[%0d]: got %h v=%b want %h v=1", i, Dato_Mem_out, Rd_valid, want[i]);
      end
    end
    access(0, 0, 4'h0, BASE, 32'h0, 0);
    checks++;
    if (Rd_valid !== 1'b0 || Dato_Mem_out !== 32'h02) begin
      errors++;
      $display("FAIL idle_hold: got %h v=%b want 00000002 v=0", Dato_Mem_out, Rd_valid);
    end
  endtask

  task automatic test_byte_en();
    access(0, 1, 4'b0101, BASE + 5, 32'hDEADBEEF, 0);
    checks++;
    if (Addr_err !== 1'b0) begin
      errors++; $display("FAIL byte_en_err: got %b want 0", Addr_err);
    end
    access(1, 0, 4'h0, BASE + 5, 32'h0, 0);
    checks++;
    if (Dato_Mem_out !== 32'h00AD00EF) begin
      errors++; $display("FAIL byte_en_read: got %h want 00ad00ef", Dato_Mem_out);
    end
  endtask

  task automatic test_read_first();
    access(1, 1, 4'hF, BASE + 2, 32'h55, 0);
    checks++;
    if (Dato_Mem_out !== 32'h0D || Rd_valid !== 1'b1) begin
      errors++; $display("FAIL read_first_old: got %h v=%b want 0000000d v=1", Dato_Mem_out, Rd_valid);
    end
    access(1, 0, 4'h0, BASE + 2, 32'h0, 0);
    checks++;
    if (Dato_Mem_out !== 32'h55) begin
      errors++; $display("FAIL read_first_new: got %h want 00000055", Dato_Mem_out);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] addrs [2];
    addrs[0] = BASE + DEP; addrs[1] = BASE - 1;
    for (int k = 0; k < 2; k++) begin
      access(1, 0, 4'h0, addrs[k], 32'h0, 0);
      checks++;
      if (Dato_Mem_out !== 32'h20 || Addr_err !== 1'b1 || Err_sticky !== 1'b1) begin
        errors++;
        $display("FAIL oor_read[%0d]: got out=%h e=%b s=%b want 00000020 1 1",
                 k, Dato_Mem_out, Addr_err, Err_sticky);
      end
      access(0, 0, 4'h0, BASE, 32'h0, 0);
      checks++;
      if (Addr_err !== 1'b0 || Err_sticky !== 1'b1) begin
        errors++; $display("FAIL oor_pulse[%0d]: got e=%b s=%b want 0 1", k, Addr_err, Err_sticky);
      end
    end
    access(0, 0, 4'h0, BASE, 32'h0, 1);
    checks++;
    if (Err_sticky !== 1'b0) begin
      errors++; $display("FAIL err_clr: got %b want 0", Err_sticky);
    end
    access(1, 0, 4'h0, BASE + DEP, 32'h0, 1);
    checks++;
    if (Err_sticky !== 1'b1) begin
      errors++; $display("FAIL clr_vs_set: got %b want 1", Err_sticky);
    end
    access(0, 0, 4'h0, BASE, 32'h0, 1);
  endtask

  task automatic test_wrap();
    access(0, 1, 4'hF, 32'hFFFFFFFF, 32'hCAFEF00D, 0);
    checks++;
    if (Addr_err !== 1'b1 || Err_sticky !== 1'b1) begin
      errors++; $display("FAIL wrap_err: got e=%b s=%b want 1 1", Addr_err, Err_sticky);
    end
    for (int i = 0; i < DEP; i++) begin
      access(1, 0, 4'h0, BASE + i, 32'h0, 0);
      checks++;
      if (Dato_Mem_out !== exp_out) begin
        errors++; $display("FAIL wrap_word[%0d]: got %h want %h", i, Dato_Mem_out, exp_out);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    Mem_wr = 1'b0; Mem_rd = 1'b1; Byte_en = 4'hF; Dir_Mem = BASE; Dato_Mem_in = 32'hAAAAAAAA;
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if ({Dato_Mem_out, Rd_valid, Addr_err, Err_sticky} !== 35'h0) begin
      errors++;
      $display("FAIL midrst_outputs: got out=%h v=%b e=%b s=%b want all 0",
               Dato_Mem_out, Rd_valid, Addr_err, Err_sticky);
    end
    @(posedge clk); #1;
    Mem_wr = 1'b1; Byte_en = 4'h0;
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    access(1, 0, 4'h0, BASE, 32'h0, 0);
    checks++;
    if (Dato_Mem_out !== 32'h10) begin
      errors++; $display("FAIL midrst_word: got %h want 00000010", Dato_Mem_out);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      bit          rd, wr, clr;
      logic [3:0]  be;
      logic [31:0] addr;
      rd   = ($urandom_range(0, 2) != 0);
      wr   = ($urandom_range(0, 1) != 0);
      clr  = ($urandom_range(0, 7) == 0);
      be   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) addr = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
      else addr = BASE - 2 + 32'($urandom_range(0, DEP + 3));
      if (wr && be == 4'h0) be = 4'h1;
      access(rd, wr, be, addr, $urandom, clr);
      checks++;
      if (Dato_Mem_out !== exp_out || Rd_valid !== exp_valid ||
          Addr_err !== exp_err || Err_sticky !== exp_sticky) begin
        errors++;
        $display("FAIL random[%0d]: got out=%h v=%b e=%b s=%b want %h %b %b %b", n,
                 Dato_Mem_out, Rd_valid, Addr_err, Err_sticky,
                 exp_out, exp_valid, exp_err, exp_sticky);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_reads();
    test_byte_en();
    test_read_first();
    test_out_of_range();
    test_wrap();
    test_reset_mid_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
